// File: rtl/vga_mem_arbiter_pkg.sv
// Shared definitions for the VGA pixel SRAM arbiter: default bus widths,
// FSM state encodings and the per-edge grant decision record.
package vga_mem_arbiter_pkg;

  localparam int ADDR_W_DEF = 18;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD      = 3'd1,
    ST_WR      = 3'd2,
    ST_WR_HOLD = 3'd3,
    ST_TURN    = 3'd4
  } state_e;

  typedef struct packed {
    logic rd;
    logic wr;
    logic forced;
  } grant_t;

endpackage

// File: rtl/vga_rd_pipe.sv
// Read-return pipeline: valid bits ride a READ_LAT-deep shift register and
// the SRAM bus is sampled on the edge where the oldest launch matures.
module vga_rd_pipe #(
  parameter int READ_LAT = 2,
  parameter int DATA_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              launch,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data
);

  // vld_pipe[i] is set i edges after the launch edge
  logic [READ_LAT:0] vld_pipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      rd_data  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[READ_LAT-1:0], launch};
      if (vld_pipe[READ_LAT-1]) rd_data <= mem_rdata;
    end
  end

  assign rd_valid = vld_pipe[READ_LAT];

endmodule

// File: rtl/vga_mem_arbiter.sv
// Display-read / draw-write arbiter for one asynchronous single-port SRAM,
// with bus turnaround, fixed read latency and write starvation relief.
module vga_mem_arbiter
  import vga_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int READ_LAT   = 2,
  parameter int TURN_CYC   = 1,
  parameter int STARVE_MAX = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_data_oe,
  output logic              mem_oe_n,
  output logic              mem_we_n,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stat_forced
);

  localparam int TW = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  state_e        state, state_nx;
  logic          last_wr, last_wr_nx;
  logic [TW-1:0] turn_cnt, turn_cnt_nx;
  logic [SW-1:0] starve_cnt, starve_cnt_nx;
  logic          starved, pick_rd, pick_wr, decide;
  grant_t        gnt;

  always_comb begin
    starved     = wr_req && (starve_cnt == SW'(STARVE_MAX));
    pick_rd     = rd_req && !starved;
    pick_wr     = wr_req && !pick_rd;
    decide      = (state inside {ST_IDLE, ST_RD, ST_WR_HOLD}) ||
                  (state == ST_TURN && turn_cnt == TW'(TURN_CYC - 1));
    state_nx    = state;
    last_wr_nx  = last_wr;
    turn_cnt_nx = turn_cnt;
    gnt         = '0;

    case (state)
      ST_WR:   state_nx = ST_WR_HOLD;
      ST_TURN: if (!decide) turn_cnt_nx = turn_cnt + 1'b1;
      default: ;
    endcase

    if (decide) begin
      state_nx = ST_IDLE;
      if (pick_rd || pick_wr) begin
        // a completed turnaround grants whichever side wins now, no second turn
        if (state != ST_TURN && pick_wr != last_wr) begin
          state_nx    = ST_TURN;
          turn_cnt_nx = '0;
        end else if (pick_rd) begin
          state_nx   = ST_RD;
          last_wr_nx = 1'b0;
          gnt.rd     = 1'b1;
        end else begin
          state_nx   = ST_WR;
          last_wr_nx = 1'b1;
          gnt.wr     = 1'b1;
          gnt.forced = starved && rd_req;
        end
      end
    end

    // the count tracks refusal of the request currently on the port
    starve_cnt_nx = starve_cnt;
    if (!wr_req || gnt.wr)                  starve_cnt_nx = '0;
    else if (starve_cnt != SW'(STARVE_MAX)) starve_cnt_nx = starve_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      last_wr     <= 1'b0;
      turn_cnt    <= '0;
      starve_cnt  <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_data_oe <= 1'b0;
      mem_oe_n    <= 1'b1;
      mem_we_n    <= 1'b1;
      rd_ack      <= 1'b0;
      wr_ack      <= 1'b0;
      stat_forced <= 1'b0;
    end else begin
      state       <= state_nx;
      last_wr     <= last_wr_nx;
      turn_cnt    <= turn_cnt_nx;
      starve_cnt  <= starve_cnt_nx;
      rd_ack      <= gnt.rd;
      wr_ack      <= gnt.wr;
      stat_forced <= gnt.forced;
      mem_oe_n    <= !gnt.rd;
      mem_we_n    <= !gnt.wr;
      mem_data_oe <= gnt.wr || (state_nx == ST_WR_HOLD);
      if (gnt.rd) begin
        mem_addr <= rd_addr;
      end else if (gnt.wr) begin
        mem_addr  <= wr_addr;
        mem_wdata <= wr_data;
      end
    end
  end

  vga_rd_pipe #(
    .READ_LAT (READ_LAT),
    .DATA_W   (DATA_W)
  ) u_rd_pipe (
    .clk       (clk),
    .rst       (rst),
    .launch    (gnt.rd),
    .mem_rdata (mem_rdata),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data)
  );

endmodule
